param_stack: RTL and testbench

- Parametrised LIFO for the stack-machine datapath. It generalises the fixed 8-bit, 1024-entry stack in width and depth.
- Adds full/empty flags, an occupancy count, and sticky overflow/underflow errors.
- Adds a replace-top operation (push and pop in the same cycle) for single-cycle ALU write-back.
- Sits between the stack-input mux (memory register / ALU result) and the A register / ALU B operand.

---
 rtl/stack_pkg.sv | 21 ++
 rtl/stack_ram.sv | 58 +++++
 rtl/param_stack.sv | 163 ++++++++++++++++
 tb/tb_param_stack.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// Shared definitions for the parametrised stack.
// Purpose : operation-decode encoding and a helper for the occupancy count width.
// Contents: op_e    - one decoded operation per cycle (idle, push, pop, tos, replace)
//           count_width() - bits needed to hold 0..depth inclusive
package stack_pkg;

    // One operation is decoded per cycle; replace has the highest priority.
    typedef enum logic [2:0] {
        OP_IDLE = 3'd0,
        OP_PUSH = 3'd1,
        OP_POP  = 3'd2,
        OP_TOS  = 3'd3,
        OP_REPL = 3'd4
    } op_e;

    // The count must represent both 0 and DEPTH, hence depth+1 states.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/stack_ram.sv
// Storage array for param_stack.
// Purpose : DEPTH x WIDTH array with one synchronous write port and one
//           registered read port. The read register is write-first: when the
//           same address is written and read on one edge, the new data is
//           returned, which is what a replace-top operation needs.
// Ports   : clk, rst       - clock and synchronous reset (clears read register only)
//           we, waddr, wdata - write port
//           re, raddr        - read request; rdata updates on the edge re is sampled
//           rdata            - registered read data, holds when re is low
module stack_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;
    logic [WIDTH-1:0] rdata_d;

    // Memory contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Write-first bypass so a same-address write and read return the new word.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            if (we && (waddr == raddr)) begin
                rdata_d = wdata;
            end else begin
                rdata_d = mem[raddr];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/param_stack.sv
// Parametrised LIFO for the stack-machine datapath.
// Purpose : push/pop/tos/replace-top stack with occupancy count, full/empty
//           flags and sticky overflow/underflow errors.
// Ports   : clk, rst          - clock, synchronous active-high reset
//           push, pop, tos    - operation requests (push&pop = replace top)
//           clr_err           - clear sticky error flags (a new error wins)
//           d_in              - data to push / replace with
//           d_out, d_valid    - registered read data and its one-cycle strobe
//           count, full, empty- occupancy and derived flags
//           overflow, underflow - sticky illegal-operation flags
module param_stack
    import stack_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 1024,
    localparam int CW    = count_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             tos,
    input  logic             clr_err,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] d_out,
    output logic             d_valid,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    output logic             underflow
);

    localparam int AW = $clog2(DEPTH);

    op_e           op;
    logic [CW-1:0] count_q, count_d;
    logic          d_valid_q, d_valid_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;

    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic          mem_re;
    logic [AW-1:0] top_addr;
    logic [AW-1:0] push_addr;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // Addresses are only used when the matching guard (not empty / not full)
    // holds, so the truncation to AW bits never loses information.
    assign top_addr  = AW'(count_q - CW'(1));
    assign push_addr = AW'(count_q);

    // Priority decode: replace, push, pop, tos, idle.
    always_comb begin
        op = OP_IDLE;
        if (push && pop) begin
            op = OP_REPL;
        end else if (push) begin
            op = OP_PUSH;
        end else if (pop) begin
            op = OP_POP;
        end else if (tos) begin
            op = OP_TOS;
        end
    end

    // Next-state and memory control. Illegal operations only touch the flags.
    always_comb begin
        count_d     = count_q;
        d_valid_d   = 1'b0;
        overflow_d  = overflow_q  & ~clr_err;
        underflow_d = underflow_q & ~clr_err;
        mem_we      = 1'b0;
        mem_waddr   = push_addr;
        mem_re      = 1'b0;

        case (op)
            OP_REPL: begin
                if (!empty) begin
                    mem_we    = 1'b1;
                    mem_waddr = top_addr;
                    mem_re    = 1'b1;
                    d_valid_d = 1'b1;
                end else begin
                    // Replace on an empty stack degrades to a plain push.
                    mem_we  = 1'b1;
                    count_d = count_q + CW'(1);
                end
            end
            OP_PUSH: begin
                if (!full) begin
                    mem_we  = 1'b1;
                    count_d = count_q + CW'(1);
                end else begin
                    overflow_d = 1'b1;
                end
            end
            OP_POP: begin
                if (!empty) begin
                    mem_re    = 1'b1;
                    count_d   = count_q - CW'(1);
                    d_valid_d = 1'b1;
                end else begin
                    underflow_d = 1'b1;
                end
            end
            OP_TOS: begin
                if (!empty) begin
                    mem_re    = 1'b1;
                    d_valid_d = 1'b1;
                end else begin
                    underflow_d = 1'b1;
                end
            end
            default: begin
            end
        endcase

        // Reset overrides every request, including memory accesses.
        if (rst) begin
            mem_we = 1'b0;
            mem_re = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q     <= '0;
            d_valid_q   <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            d_valid_q   <= d_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    stack_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (d_in),
        .re    (mem_re),
        .raddr (top_addr),
        .rdata (d_out)
    );

    assign count     = count_q;
    assign d_valid   = d_valid_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_param_stack.sv
// Directed testbench for param_stack configured as an 8-bit, 4-entry stack.
module tb_param_stack;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk;
    logic             rst;
    logic             push;
    logic             pop;
    logic             tos;
    logic             clr_err;
    logic [WIDTH-1:0] d_in;
    logic [WIDTH-1:0] d_out;
    logic             d_valid;
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;
    logic             overflow;
    logic             underflow;

    int pass_cnt;
    int total_cnt;

    param_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .tos       (tos),
        .clr_err   (clr_err),
        .d_in      (d_in),
        .d_out     (d_out),
        .d_valid   (d_valid),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .underflow (underflow)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one cycle of requests, lets the edge sample them, then returns
    // the inputs to idle 1 ns after the edge where outputs are stable.
    task automatic cycle(input logic r, input logic pu, input logic po,
                         input logic t, input logic ce, input logic [WIDTH-1:0] d);
        rst = r; push = pu; pop = po; tos = t; clr_err = ce; d_in = d;
        @(posedge clk);
        #1;
        rst = 1'b0; push = 1'b0; pop = 1'b0; tos = 1'b0; clr_err = 1'b0; d_in = '0;
    endtask

    task automatic test_reset();
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        total_cnt++; if (count !== 3'd0) $display("[TB] FAIL reset_count got %0d want 0", count); else pass_cnt++;
        total_cnt++; if (d_out !== 8'h00) $display("[TB] FAIL reset_dout got %h want 00", d_out); else pass_cnt++;
        total_cnt++; if (d_valid !== 1'b0) $display("[TB] FAIL reset_dvalid got %b want 0", d_valid); else pass_cnt++;
        total_cnt++; if ({overflow, underflow} !== 2'b00) $display("[TB] FAIL reset_flags got %b want 00", {overflow, underflow}); else pass_cnt++;
        total_cnt++; if ({full, empty} !== 2'b01) $display("[TB] FAIL reset_full_empty got %b want 01", {full, empty}); else pass_cnt++;
    endtask

    task automatic test_push_pop();
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h06);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h08);
        total_cnt++; if (count !== 3'd2) $display("[TB] FAIL pp_count2 got %0d want 2", count); else pass_cnt++;
        total_cnt++; if (d_valid !== 1'b0) $display("[TB] FAIL pp_push_dvalid got %b want 0", d_valid); else pass_cnt++;
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        total_cnt++; if ({d_valid, d_out} !== {1'b1, 8'h08}) $display("[TB] FAIL pp_pop1 got %b/%h want 1/08", d_valid, d_out); else pass_cnt++;
        total_cnt++; if (count !== 3'd1) $display("[TB] FAIL pp_count1 got %0d want 1", count); else pass_cnt++;
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        total_cnt++; if ({d_valid, d_out} !== {1'b0, 8'h08}) $display("[TB] FAIL pp_idle got %b/%h want 0/08", d_valid, d_out); else pass_cnt++;
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        total_cnt++; if ({d_valid, d_out} !== {1'b1, 8'h06}) $display("[TB] FAIL pp_pop2 got %b/%h want 1/06", d_valid, d_out); else pass_cnt++;
        total_cnt++; if ({count, empty} !== {3'd0, 1'b1}) $display("[TB] FAIL pp_empty got %0d/%b want 0/1", count, empty); else pass_cnt++;
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 4; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'(i));
            total_cnt++;
            if (full !== (i == 4)) $display("[TB] FAIL ovf_full_%0d got %b want %b", i, full, (i == 4)); else pass_cnt++;
        end
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h05);
        total_cnt++; if (overflow !== 1'b1) $display("[TB] FAIL ovf_flag got %b want 1", overflow); else pass_cnt++;
        total_cnt++; if ({count, full, empty} !== {3'd4, 1'b1, 1'b0}) $display("[TB] FAIL ovf_count got %0d/%b/%b want 4/1/0", count, full, empty); else pass_cnt++;
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        total_cnt++; if ({d_valid, d_out} !== {1'b1, 8'h04}) $display("[TB] FAIL ovf_pop got %b/%h want 1/04", d_valid, d_out); else pass_cnt++;
        total_cnt++; if (overflow !== 1'b1) $display("[TB] FAIL ovf_sticky got %b want 1", overflow); else pass_cnt++;
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        total_cnt++; if (overflow !== 1'b0) $display("[TB] FAIL ovf_clear got %b want 0", overflow); else pass_cnt++;
        for (int i = 3; i >= 1; i--) begin
            cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
            total_cnt++;
            if (d_out !== 8'(i)) $display("[TB] FAIL ovf_drain_%0d got %h want %h", i, d_out, 8'(i)); else pass_cnt++;
        end
    endtask

    // Stack is empty and d_out holds 0x01 from the previous drain.
    task automatic test_underflow();
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        total_cnt++; if (underflow !== 1'b1) $display("[TB] FAIL unf_pop got %b want 1", underflow); else pass_cnt++;
        total_cnt++; if ({d_valid, d_out, count} !== {1'b0, 8'h01, 3'd0}) $display("[TB] FAIL unf_pop_state got %b/%h/%0d want 0/01/0", d_valid, d_out, count); else pass_cnt++;
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        total_cnt++; if ({underflow, d_valid, d_out, count} !== {1'b1, 1'b0, 8'h01, 3'd0}) $display("[TB] FAIL unf_tos got %b/%b/%h/%0d want 1/0/01/0", underflow, d_valid, d_out, count); else pass_cnt++;
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        total_cnt++; if (underflow !== 1'b0) $display("[TB] FAIL unf_clear got %b want 0", underflow); else pass_cnt++;
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
        total_cnt++; if (underflow !== 1'b1) $display("[TB] FAIL unf_set_wins got %b want 1", underflow); else pass_cnt++;
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        total_cnt++; if (underflow !== 1'b0) $display("[TB] FAIL unf_clear2 got %b want 0", underflow); else pass_cnt++;
    endtask

    task automatic test_replace();
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h03);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h06);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h0E);
        total_cnt++; if ({count, d_valid, d_out} !== {3'd2, 1'b1, 8'h0E}) $display("[TB] FAIL repl got %0d/%b/%h want 2/1/0e", count, d_valid, d_out); else pass_cnt++;
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        total_cnt++; if ({count, d_valid, d_out} !== {3'd2, 1'b1, 8'h0E}) $display("[TB] FAIL repl_tos got %0d/%b/%h want 2/1/0e", count, d_valid, d_out); else pass_cnt++;
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        total_cnt++; if ({count, d_out} !== {3'd1, 8'h0E}) $display("[TB] FAIL repl_pop1 got %0d/%h want 1/0e", count, d_out); else pass_cnt++;
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        total_cnt++; if ({count, d_out} !== {3'd0, 8'h03}) $display("[TB] FAIL repl_pop2 got %0d/%h want 0/03", count, d_out); else pass_cnt++;
        // Replace on an empty stack acts as a push and raises no error.
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h55);
        total_cnt++; if ({count, d_valid, underflow, d_out} !== {3'd1, 1'b0, 1'b0, 8'h03}) $display("[TB] FAIL repl_empty got %0d/%b/%b/%h want 1/0/0/03", count, d_valid, underflow, d_out); else pass_cnt++;
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        total_cnt++; if ({count, d_out} !== {3'd0, 8'h55}) $display("[TB] FAIL repl_empty_pop got %0d/%h want 0/55", count, d_out); else pass_cnt++;
    endtask

    task automatic test_tos_ignored();
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h11);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        total_cnt++; if ({count, d_valid, d_out} !== {3'd1, 1'b1, 8'h11}) $display("[TB] FAIL tos_after_push got %0d/%b/%h want 1/1/11", count, d_valid, d_out); else pass_cnt++;
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h22);
        total_cnt++; if ({count, d_valid, d_out} !== {3'd2, 1'b0, 8'h11}) $display("[TB] FAIL tos_with_push got %0d/%b/%h want 2/0/11", count, d_valid, d_out); else pass_cnt++;
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        total_cnt++; if (d_out !== 8'h22) $display("[TB] FAIL tos_pop1 got %h want 22", d_out); else pass_cnt++;
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        total_cnt++; if ({count, d_out} !== {3'd0, 8'h11}) $display("[TB] FAIL tos_pop2 got %0d/%h want 0/11", count, d_out); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA1);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA2);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA3);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        total_cnt++; if ({count, d_out, underflow} !== {3'd3, 8'hA3, 1'b1}) $display("[TB] FAIL rmid_pre got %0d/%h/%b want 3/a3/1", count, d_out, underflow); else pass_cnt++;
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA4);
        total_cnt++; if ({count, d_out, d_valid} !== {3'd0, 8'h00, 1'b0}) $display("[TB] FAIL rmid_state got %0d/%h/%b want 0/00/0", count, d_out, d_valid); else pass_cnt++;
        total_cnt++; if ({overflow, underflow, empty} !== 3'b001) $display("[TB] FAIL rmid_flags got %b want 001", {overflow, underflow, empty}); else pass_cnt++;
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        total_cnt++; if ({underflow, d_valid, count} !== {1'b1, 1'b0, 3'd0}) $display("[TB] FAIL rmid_pop got %b/%b/%0d want 1/0/0", underflow, d_valid, count); else pass_cnt++;
    endtask

    initial begin
        pass_cnt = 0;
        total_cnt = 0;
        rst = 1'b0; push = 1'b0; pop = 1'b0; tos = 1'b0; clr_err = 1'b0; d_in = '0;
        @(negedge clk);
        test_reset();
        test_push_pop();
        test_overflow();
        test_underflow();
        test_replace();
        test_tos_ignored();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
